// File: rtl/pong_game_ctrl.sv
// Game-level sequencer for the pong graphics path: serve/play/game-over state,
// lives, BCD score, ball-motion gating and frame-synchronous ball speed.
module pong_game_ctrl #(
    parameter int LIVES         = 3,
    parameter int NEWBALL_TICKS = 120,
    parameter int OVER_TICKS    = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        refr_tick,
    input  logic        btn_start,
    input  logic        hit,
    input  logic        miss,
    input  logic        adc_drdy,
    input  logic [11:0] adc_data,
    output logic [7:0]  speed,
    output logic        ball_still,
    output logic        game_over,
    output logic [1:0]  state,
    output logic [1:0]  lives,
    output logic [3:0]  score_hi,
    output logic [3:0]  score_lo
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_NEWBALL = 2'b01,
        ST_PLAY    = 2'b10,
        ST_OVER    = 2'b11
    } state_t;

    localparam logic [7:0] NEWBALL_LAST = 8'(NEWBALL_TICKS - 1);
    localparam logic [7:0] OVER_LAST    = 8'(OVER_TICKS - 1);
    localparam logic [1:0] LIVES_INIT   = 2'(LIVES);

    state_t      state_q;
    logic [7:0]  timer_q;
    logic [1:0]  lives_q;
    logic [3:0]  score_hi_q;
    logic [3:0]  score_lo_q;
    logic [3:0]  score_hi_d;
    logic [3:0]  score_lo_d;
    logic [2:0]  pending_q;
    logic [7:0]  speed_q;
    logic        btn_prev_q;
    logic        ball_still_q;
    logic        game_over_q;

    logic        start_edge;
    logic [7:0]  timer_last;
    logic        timer_done;

    // Only the top three ADC bits select the speed step.
    logic        unused_adc_bits;
    assign unused_adc_bits = ^adc_data[8:0];

    assign start_edge = btn_start & ~btn_prev_q;
    assign timer_last = (state_q == ST_OVER) ? OVER_LAST : NEWBALL_LAST;
    assign timer_done = refr_tick && (timer_q == timer_last);

    // BCD increment with 99 -> 00 wrap.
    always_comb begin
        score_hi_d = score_hi_q;
        score_lo_d = score_lo_q + 4'd1;
        if (score_lo_q == 4'd9) begin
            score_lo_d = 4'd0;
            score_hi_d = (score_hi_q == 4'd9) ? 4'd0 : score_hi_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            timer_q      <= 8'd0;
            lives_q      <= LIVES_INIT;
            score_hi_q   <= 4'd0;
            score_lo_q   <= 4'd0;
            pending_q    <= 3'd0;
            speed_q      <= 8'd1;
            btn_prev_q   <= 1'b0;
            ball_still_q <= 1'b1;
            game_over_q  <= 1'b0;
        end else begin
            btn_prev_q <= btn_start;

            // Speed only moves at frame boundaries; a sample arriving on the
            // same cycle as refr_tick is picked up at the following frame.
            if (adc_drdy) begin
                pending_q <= adc_data[11:9];
            end
            if (refr_tick) begin
                speed_q <= {5'b0, pending_q} + 8'd1;
                timer_q <= timer_q + 8'd1;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_edge) begin
                        lives_q      <= LIVES_INIT;
                        score_hi_q   <= 4'd0;
                        score_lo_q   <= 4'd0;
                        state_q      <= ST_NEWBALL;
                        timer_q      <= 8'd0;
                        ball_still_q <= 1'b1;
                        game_over_q  <= 1'b0;
                    end
                end
                ST_NEWBALL: begin
                    if (timer_done) begin
                        state_q      <= ST_PLAY;
                        timer_q      <= 8'd0;
                        ball_still_q <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    // A miss takes priority and swallows a coincident hit.
                    if (miss) begin
                        timer_q      <= 8'd0;
                        ball_still_q <= 1'b1;
                        if (lives_q > 2'd1) begin
                            lives_q <= lives_q - 2'd1;
                            state_q <= ST_NEWBALL;
                        end else begin
                            lives_q     <= 2'd0;
                            state_q     <= ST_OVER;
                            game_over_q <= 1'b1;
                        end
                    end else if (hit) begin
                        score_hi_q <= score_hi_d;
                        score_lo_q <= score_lo_d;
                    end
                end
                ST_OVER: begin
                    if (timer_done) begin
                        state_q      <= ST_IDLE;
                        timer_q      <= 8'd0;
                        ball_still_q <= 1'b1;
                        game_over_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign lives      = lives_q;
    assign score_hi   = score_hi_q;
    assign score_lo   = score_lo_q;
    assign speed      = speed_q;
    assign ball_still = ball_still_q;
    assign game_over  = game_over_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with short serve/game-over delays.
module tb_pong_game_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        refr_tick = 1'b0;
    logic        btn_start = 1'b0;
    logic        hit = 1'b0;
    logic        miss = 1'b0;
    logic        adc_drdy = 1'b0;
    logic [11:0] adc_data = 12'h000;
    logic [7:0]  speed;
    logic        ball_still;
    logic        game_over;
    logic [1:0]  state;
    logic [1:0]  lives;
    logic [3:0]  score_hi;
    logic [3:0]  score_lo;

    int n_cmp = 0;
    int n_bad = 0;

    pong_game_ctrl #(
        .LIVES(3),
        .NEWBALL_TICKS(4),
        .OVER_TICKS(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .refr_tick(refr_tick),
        .btn_start(btn_start),
        .hit(hit),
        .miss(miss),
        .adc_drdy(adc_drdy),
        .adc_data(adc_data),
        .speed(speed),
        .ball_still(ball_still),
        .game_over(game_over),
        .state(state),
        .lives(lives),
        .score_hi(score_hi),
        .score_lo(score_lo)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_refr();
        refr_tick = 1'b1;
        step();
        refr_tick = 1'b0;
    endtask

    task automatic pulse_hits(input int n);
        hit = 1'b1;
        repeat (n) step();
        hit = 1'b0;
    endtask

    task automatic pulse_miss();
        miss = 1'b1;
        step();
        miss = 1'b0;
    endtask

    task automatic serve_to_play();
        repeat (4) pulse_refr();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        step();
        $display("reset released: state=%b lives=%0d score=%0h%0h speed=%0d", state, lives, score_hi, score_lo, speed);
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL reset_state: got %b expected 00", state); end
        n_cmp++; if (ball_still !== 1'b1) begin n_bad++; $display("FAIL reset_ball_still: got %b expected 1", ball_still); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL reset_game_over: got %b expected 0", game_over); end
        n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL reset_lives: got %0d expected 3", lives); end
        n_cmp++; if ({score_hi, score_lo} !== 8'h00) begin n_bad++; $display("FAIL reset_score: got %0h%0h expected 00", score_hi, score_lo); end
        n_cmp++; if (speed !== 8'd1) begin n_bad++; $display("FAIL reset_speed: got %0d expected 1", speed); end
    endtask

    task automatic test_start();
        btn_start = 1'b1;
        step();
        $display("start pressed: state=%b", state);
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL start_newball: got %b expected 01", state); end
        n_cmp++; if (ball_still !== 1'b1) begin n_bad++; $display("FAIL start_still: got %b expected 1", ball_still); end
        // Non-tick cycles between refresh ticks must not advance the serve timer.
        for (int i = 0; i < 3; i++) begin
            pulse_refr();
            repeat (2) step();
        end
        $display("after 3 refr ticks: state=%b", state);
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL serve_early: got %b expected 01", state); end
        pulse_refr();
        $display("after 4 refr ticks: state=%b ball_still=%b", state, ball_still);
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL serve_done: got %b expected 10", state); end
        n_cmp++; if (ball_still !== 1'b0) begin n_bad++; $display("FAIL play_moving: got %b expected 0", ball_still); end
        repeat (3) step();
        btn_start = 1'b0;
        n_cmp++; if (state !== 2'b10) begin n_bad++; $display("FAIL start_hold: got %b expected 10", state); end
    endtask

    task automatic test_score();
        pulse_hits(10);
        $display("10 hits: score=%0h%0h", score_hi, score_lo);
        n_cmp++; if ({score_hi, score_lo} !== 8'h10) begin n_bad++; $display("FAIL score_10: got %0h%0h expected 10", score_hi, score_lo); end
        pulse_hits(89);
        $display("99 hits: score=%0h%0h", score_hi, score_lo);
        n_cmp++; if ({score_hi, score_lo} !== 8'h99) begin n_bad++; $display("FAIL score_99: got %0h%0h expected 99", score_hi, score_lo); end
        pulse_hits(1);
        $display("100 hits: score=%0h%0h", score_hi, score_lo);
        n_cmp++; if ({score_hi, score_lo} !== 8'h00) begin n_bad++; $display("FAIL score_wrap: got %0h%0h expected 00", score_hi, score_lo); end
    endtask

    task automatic test_miss();
        pulse_miss();
        $display("miss 1: lives=%0d state=%b", lives, state);
        n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL miss1_lives: got %0d expected 2", lives); end
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL miss1_state: got %b expected 01", state); end
        n_cmp++; if (ball_still !== 1'b1) begin n_bad++; $display("FAIL miss1_still: got %b expected 1", ball_still); end
        serve_to_play();
        pulse_miss();
        $display("miss 2: lives=%0d state=%b", lives, state);
        n_cmp++; if (lives !== 2'd1) begin n_bad++; $display("FAIL miss2_lives: got %0d expected 1", lives); end
        serve_to_play();
        pulse_hits(3);
        pulse_miss();
        $display("miss 3: lives=%0d state=%b game_over=%b", lives, state, game_over);
        n_cmp++; if (lives !== 2'd0) begin n_bad++; $display("FAIL miss3_lives: got %0d expected 0", lives); end
        n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL miss3_state: got %b expected 11", state); end
        n_cmp++; if (game_over !== 1'b1) begin n_bad++; $display("FAIL miss3_over: got %b expected 1", game_over); end
        // Press start during OVER: ignored, and still held when IDLE arrives.
        btn_start = 1'b1;
        pulse_refr();
        pulse_refr();
        n_cmp++; if (state !== 2'b11) begin n_bad++; $display("FAIL over_early: got %b expected 11", state); end
        pulse_refr();
        $display("over done: state=%b score=%0h%0h lives=%0d", state, score_hi, score_lo, lives);
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL over_done: got %b expected 00", state); end
        n_cmp++; if (game_over !== 1'b0) begin n_bad++; $display("FAIL over_cleared: got %b expected 0", game_over); end
        n_cmp++; if ({score_hi, score_lo} !== 8'h03) begin n_bad++; $display("FAIL over_score_kept: got %0h%0h expected 03", score_hi, score_lo); end
        n_cmp++; if (lives !== 2'd0) begin n_bad++; $display("FAIL over_lives_kept: got %0d expected 0", lives); end
        repeat (3) step();
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL held_no_retrigger: got %b expected 00", state); end
        btn_start = 1'b0;
        step();
    endtask

    task automatic test_speed();
        adc_data = 12'hFFF; adc_drdy = 1'b1;
        step();
        adc_drdy = 1'b0;
        repeat (2) step();
        n_cmp++; if (speed !== 8'd1) begin n_bad++; $display("FAIL speed_midframe: got %0d expected 1", speed); end
        pulse_refr();
        $display("adc FFF + refr: speed=%0d", speed);
        n_cmp++; if (speed !== 8'd8) begin n_bad++; $display("FAIL speed_fff: got %0d expected 8", speed); end
        adc_data = 12'h3FF; adc_drdy = 1'b1;
        step();
        adc_drdy = 1'b0;
        pulse_refr();
        $display("adc 3FF + refr: speed=%0d", speed);
        n_cmp++; if (speed !== 8'd2) begin n_bad++; $display("FAIL speed_3ff: got %0d expected 2", speed); end
        adc_data = 12'h800; adc_drdy = 1'b1;
        step();
        adc_data = 12'hFFF; refr_tick = 1'b1;
        step();
        adc_drdy = 1'b0; refr_tick = 1'b0;
        $display("coincident drdy/refr: speed=%0d", speed);
        n_cmp++; if (speed !== 8'd5) begin n_bad++; $display("FAIL speed_coincident: got %0d expected 5", speed); end
        pulse_refr();
        n_cmp++; if (speed !== 8'd8) begin n_bad++; $display("FAIL speed_deferred: got %0d expected 8", speed); end
    endtask

    task automatic test_hit_miss_same();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        n_cmp++; if ({state, lives, score_hi, score_lo} !== {2'b01, 2'd3, 8'h00}) begin n_bad++; $display("FAIL restart: got st=%b lv=%0d sc=%0h%0h expected st=01 lv=3 sc=00", state, lives, score_hi, score_lo); end
        serve_to_play();
        pulse_hits(5);
        hit = 1'b1; miss = 1'b1;
        step();
        hit = 1'b0; miss = 1'b0;
        $display("hit+miss: score=%0h%0h lives=%0d state=%b", score_hi, score_lo, lives, state);
        n_cmp++; if ({score_hi, score_lo} !== 8'h05) begin n_bad++; $display("FAIL hitmiss_score: got %0h%0h expected 05", score_hi, score_lo); end
        n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL hitmiss_lives: got %0d expected 2", lives); end
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL hitmiss_state: got %b expected 01", state); end
        pulse_hits(2);
        pulse_miss();
        btn_start = 1'b1;
        step();
        btn_start = 1'b0;
        $display("inputs in NEWBALL: score=%0h%0h lives=%0d state=%b", score_hi, score_lo, lives, state);
        n_cmp++; if ({score_hi, score_lo} !== 8'h05) begin n_bad++; $display("FAIL newball_hit_ignored: got %0h%0h expected 05", score_hi, score_lo); end
        n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL newball_miss_ignored: got %0d expected 2", lives); end
        n_cmp++; if (state !== 2'b01) begin n_bad++; $display("FAIL newball_start_ignored: got %b expected 01", state); end
    endtask

    task automatic test_reset_mid();
        serve_to_play();
        pulse_hits(37);
        $display("before reset: state=%b score=%0h%0h lives=%0d", state, score_hi, score_lo, lives);
        n_cmp++; if ({state, lives, score_hi, score_lo} !== {2'b10, 2'd2, 8'h42}) begin n_bad++; $display("FAIL pre_reset: got st=%b lv=%0d sc=%0h%0h expected st=10 lv=2 sc=42", state, lives, score_hi, score_lo); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        $display("async reset: state=%b score=%0h%0h lives=%0d speed=%0d", state, score_hi, score_lo, lives, speed);
        n_cmp++; if (state !== 2'b00) begin n_bad++; $display("FAIL areset_state: got %b expected 00", state); end
        n_cmp++; if ({score_hi, score_lo} !== 8'h00) begin n_bad++; $display("FAIL areset_score: got %0h%0h expected 00", score_hi, score_lo); end
        n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL areset_lives: got %0d expected 3", lives); end
        n_cmp++; if (speed !== 8'd1) begin n_bad++; $display("FAIL areset_speed: got %0d expected 1", speed); end
        n_cmp++; if (ball_still !== 1'b1) begin n_bad++; $display("FAIL areset_still: got %b expected 1", ball_still); end
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_start();
        test_score();
        test_miss();
        test_speed();
        test_hit_miss_same();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
